// File: rtl/spi_cs_xfer_ctrl.sv
// Multi-byte SPI transaction controller: frames a burst of engine byte transfers with one
// chip-select and enforces CS setup, hold and deselect timing in clock cycles.
module spi_cs_xfer_ctrl #(
    parameter int unsigned MAX_BYTES        = 4,
    parameter int unsigned CS_SETUP_CLKS    = 2,
    parameter int unsigned CS_HOLD_CLKS     = 2,
    parameter int unsigned CS_INACTIVE_CLKS = 4,
    localparam int unsigned CW = $clog2(MAX_BYTES + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [CW-1:0] i_TX_Count,
    input  logic [7:0]    i_TX_Byte,
    input  logic          i_TX_DV,
    output logic          o_TX_Ready,
    output logic [CW-1:0] o_RX_Count,
    output logic          o_RX_DV,
    output logic [7:0]    o_RX_Byte,
    output logic [7:0]    o_M_TX_Byte,
    output logic          o_M_TX_DV,
    input  logic          i_M_TX_Ready,
    input  logic          i_M_RX_DV,
    input  logic [7:0]    i_M_RX_Byte,
    output logic          o_SPI_CS_n
);

    localparam int unsigned TMAX =
        (CS_SETUP_CLKS > CS_HOLD_CLKS) ?
            ((CS_SETUP_CLKS > CS_INACTIVE_CLKS) ? CS_SETUP_CLKS : CS_INACTIVE_CLKS) :
            ((CS_HOLD_CLKS > CS_INACTIVE_CLKS) ? CS_HOLD_CLKS : CS_INACTIVE_CLKS);
    localparam int unsigned TW = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StXfer,
        StNext,
        StHold,
        StInactive
    } state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [CW-1:0]   rem_q, rem_d;
    logic [CW-1:0]   rx_count_q, rx_count_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic [7:0]      m_tx_byte_q, m_tx_byte_d;
    logic            rx_dv_q, rx_dv_d;
    logic            m_tx_dv_q, m_tx_dv_d;
    logic            cs_n_q, cs_n_d;
    logic            tx_ready_q, tx_ready_d;
    logic            accept;

    assign accept = i_TX_DV && tx_ready_q;

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        rem_d       = rem_q;
        rx_count_d  = rx_count_q;
        rx_byte_d   = rx_byte_q;
        m_tx_byte_d = m_tx_byte_q;
        rx_dv_d     = 1'b0;
        m_tx_dv_d   = 1'b0;
        cs_n_d      = cs_n_q;

        case (state_q)
            StIdle: begin
                cs_n_d = 1'b1;
                if (accept && (i_TX_Count != '0)) begin
                    m_tx_byte_d = i_TX_Byte;
                    rem_d       = (i_TX_Count > CW'(MAX_BYTES)) ? CW'(MAX_BYTES) : i_TX_Count;
                    rx_count_d  = '0;
                    tmr_d       = '0;
                    cs_n_d      = 1'b0;
                    state_d     = StSetup;
                end
            end
            StSetup: begin
                if (tmr_q == TW'(CS_SETUP_CLKS - 1)) begin
                    tmr_d     = '0;
                    m_tx_dv_d = 1'b1;
                    state_d   = StXfer;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StXfer: begin
                if (i_M_RX_DV) begin
                    rx_dv_d    = 1'b1;
                    rx_byte_d  = i_M_RX_Byte;
                    rx_count_d = rx_count_q + CW'(1);
                    rem_d      = rem_q - CW'(1);
                    state_d    = (rem_q == CW'(1)) ? StHold : StNext;
                end
            end
            StNext: begin
                if (accept) begin
                    m_tx_byte_d = i_TX_Byte;
                    m_tx_dv_d   = 1'b1;
                    state_d     = StXfer;
                end
            end
            StHold: begin
                // Hold count only starts once the engine has gone idle again.
                if ((tmr_q != '0) || i_M_TX_Ready) begin
                    if (tmr_q == TW'(CS_HOLD_CLKS - 1)) begin
                        tmr_d   = '0;
                        cs_n_d  = 1'b1;
                        state_d = StInactive;
                    end else begin
                        tmr_d = tmr_q + TW'(1);
                    end
                end
            end
            StInactive: begin
                if (tmr_q == TW'(CS_INACTIVE_CLKS - 1)) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: begin
                cs_n_d  = 1'b1;
                tmr_d   = '0;
                state_d = StIdle;
            end
        endcase

        tx_ready_d = i_M_TX_Ready && ((state_d == StIdle) || (state_d == StNext));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            tmr_q       <= '0;
            rem_q       <= '0;
            rx_count_q  <= '0;
            rx_byte_q   <= '0;
            m_tx_byte_q <= '0;
            rx_dv_q     <= 1'b0;
            m_tx_dv_q   <= 1'b0;
            cs_n_q      <= 1'b1;
            tx_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            rem_q       <= rem_d;
            rx_count_q  <= rx_count_d;
            rx_byte_q   <= rx_byte_d;
            m_tx_byte_q <= m_tx_byte_d;
            rx_dv_q     <= rx_dv_d;
            m_tx_dv_q   <= m_tx_dv_d;
            cs_n_q      <= cs_n_d;
            tx_ready_q  <= tx_ready_d;
        end
    end

    assign o_TX_Ready  = tx_ready_q;
    assign o_RX_Count  = rx_count_q;
    assign o_RX_DV     = rx_dv_q;
    assign o_RX_Byte   = rx_byte_q;
    assign o_M_TX_Byte = m_tx_byte_q;
    assign o_M_TX_DV   = m_tx_dv_q;
    assign o_SPI_CS_n  = cs_n_q;

endmodule

// File: tb/tb_spi_cs_xfer_ctrl.sv
// Directed bench for spi_cs_xfer_ctrl with a loopback byte-engine model and a cycle monitor.
module tb_spi_cs_xfer_ctrl;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] tx_count = '0;
    logic [7:0]    tx_byte = '0;
    logic          tx_dv = 1'b0;
    logic          tx_ready;
    logic [CW-1:0] rx_count;
    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic [7:0]    m_tx_byte;
    logic          m_tx_dv;
    logic          m_rdy;
    logic          m_rx_dv;
    logic [7:0]    m_rx_byte;
    logic          cs_n;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    spi_cs_xfer_ctrl #(
        .MAX_BYTES       (4),
        .CS_SETUP_CLKS   (2),
        .CS_HOLD_CLKS    (2),
        .CS_INACTIVE_CLKS(4)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_TX_Count  (tx_count),
        .i_TX_Byte   (tx_byte),
        .i_TX_DV     (tx_dv),
        .o_TX_Ready  (tx_ready),
        .o_RX_Count  (rx_count),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte),
        .o_M_TX_Byte (m_tx_byte),
        .o_M_TX_DV   (m_tx_dv),
        .i_M_TX_Ready(m_rdy),
        .i_M_RX_DV   (m_rx_dv),
        .i_M_RX_Byte (m_rx_byte),
        .o_SPI_CS_n  (cs_n)
    );

    // Byte engine: RX strobe 5 cycles after DV (loopback), ready returns one cycle later.
    logic [2:0] eng_cnt;
    logic [7:0] eng_sh;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_rdy     <= 1'b1;
            m_rx_dv   <= 1'b0;
            m_rx_byte <= 8'h00;
            eng_cnt   <= 3'd0;
            eng_sh    <= 8'h00;
        end else begin
            m_rx_dv <= 1'b0;
            if (m_tx_dv && m_rdy) begin
                m_rdy   <= 1'b0;
                eng_cnt <= 3'd6;
                eng_sh  <= m_tx_byte;
            end else if (eng_cnt != 3'd0) begin
                eng_cnt <= eng_cnt - 3'd1;
                if (eng_cnt == 3'd2) begin
                    m_rx_dv   <= 1'b1;
                    m_rx_byte <= eng_sh;
                end
                if (eng_cnt == 3'd1) m_rdy <= 1'b1;
            end
        end
    end

    // Monitor: event counters and timestamps sampled on the falling edge.
    int   cyc = 0;
    int   cs_falls = 0, cs_rises = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
    int   mtx_n = 0, mtx_cyc = 0, mtx_b2b = 0, mtx_cs_hi = 0;
    int   mrdy_rise_cyc = 0, txr_rise_cyc = 0, bad_ready = 0;
    int   rx_n = 0;
    logic [7:0]    rx_log_b [32];
    logic [CW-1:0] rx_log_c [32];
    logic cs_prev = 1'b1, mtx_prev = 1'b0, mrdy_prev = 1'b1, txr_prev = 1'b0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (cs_prev && !cs_n) begin cs_falls = cs_falls + 1; cs_fall_cyc = cyc; end
        if (!cs_prev && cs_n) begin cs_rises = cs_rises + 1; cs_rise_cyc = cyc; end
        if (m_tx_dv) begin
            mtx_n = mtx_n + 1;
            mtx_cyc = cyc;
            if (mtx_prev) mtx_b2b = mtx_b2b + 1;
            if (cs_n) mtx_cs_hi = mtx_cs_hi + 1;
        end
        if (!mrdy_prev && m_rdy) mrdy_rise_cyc = cyc;
        if (!txr_prev && tx_ready) txr_rise_cyc = cyc;
        if (tx_ready && !mrdy_prev) bad_ready = bad_ready + 1;
        if (rx_dv) begin
            if (rx_n < 32) begin
                rx_log_b[rx_n] = rx_byte;
                rx_log_c[rx_n] = rx_count;
            end
            rx_n = rx_n + 1;
        end
        cs_prev = cs_n; mtx_prev = m_tx_dv; mrdy_prev = m_rdy; txr_prev = tx_ready;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            step();
            n = n + 1;
        end
        chk(tag, 32'(tx_ready), 32'd1);
    endtask

    task automatic send(input logic [CW-1:0] cnt, input logic [7:0] b);
        tx_count = cnt;
        tx_byte  = b;
        tx_dv    = 1'b1;
        step();
        tx_dv    = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int b_fall, b_rise, b_mtx, b_rx;

    initial begin
        // Reset state
        step(); step();
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_dv", 32'(rx_dv), 32'd0);
        chk("rst_m_tx_dv", 32'(m_tx_dv), 32'd0);
        chk("rst_rx_count", 32'(rx_count), 32'd0);
        chk("rst_bytes", {16'h0, rx_byte, m_tx_byte}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(tx_ready), 32'd1);

        // Single byte 0xA5
        b_rx = rx_n;
        send(3'd1, 8'hA5);
        chk("t1_cs_low", 32'(cs_n), 32'd0);
        wait_ready("t1_done");
        chk("t1_setup", 32'(mtx_cyc - cs_fall_cyc), 32'd2);
        chk("t1_rx_n", 32'(rx_n - b_rx), 32'd1);
        chk("t1_rx_byte", 32'(rx_log_b[b_rx]), 32'hA5);
        chk("t1_rx_cnt", 32'(rx_log_c[b_rx]), 32'd1);
        chk("t1_hold", 32'(cs_rise_cyc - mrdy_rise_cyc), 32'd2);
        chk("t1_inactive", 32'(txr_rise_cyc - cs_rise_cyc), 32'd4);

        // Burst of three
        b_fall = cs_falls; b_rise = cs_rises; b_mtx = mtx_n; b_rx = rx_n;
        send(3'd3, 8'h11);
        wait_ready("t2_r2");
        send(3'd0, 8'h22);
        wait_ready("t2_r3");
        send(3'd0, 8'h33);
        wait_ready("t2_done");
        chk("t2_falls", 32'(cs_falls - b_fall), 32'd1);
        chk("t2_rises", 32'(cs_rises - b_rise), 32'd1);
        chk("t2_mtx", 32'(mtx_n - b_mtx), 32'd3);
        chk("t2_rx_n", 32'(rx_n - b_rx), 32'd3);
        chk("t2_rx_b", {8'h0, rx_log_b[b_rx], rx_log_b[b_rx+1], rx_log_b[b_rx+2]}, 32'h112233);
        chk("t2_rx_c", {29'h0, rx_log_c[b_rx]} * 100 + 32'(rx_log_c[b_rx+1]) * 10
            + 32'(rx_log_c[b_rx+2]), 32'd123);

        // Count 0 ignored, count 7 clamped to 4
        b_fall = cs_falls; b_mtx = mtx_n;
        send(3'd0, 8'h99);
        repeat (10) step();
        chk("t3_zero_cs", 32'(cs_falls - b_fall), 32'd0);
        chk("t3_zero_mtx", 32'(mtx_n - b_mtx), 32'd0);
        chk("t3_zero_ready", 32'(tx_ready), 32'd1);
        b_rise = cs_rises; b_rx = rx_n;
        send(3'd7, 8'hC1);
        wait_ready("t3_r2");
        send(3'd0, 8'hC2);
        wait_ready("t3_r3");
        send(3'd0, 8'hC3);
        wait_ready("t3_r4");
        send(3'd0, 8'hC4);
        wait_ready("t3_done");
        chk("t3_mtx", 32'(mtx_n - b_mtx), 32'd4);
        chk("t3_rx_n", 32'(rx_n - b_rx), 32'd4);
        chk("t3_last", {rx_log_b[b_rx+3], 5'h0, rx_log_c[b_rx+3]}, 16'hC404);
        chk("t3_rises", 32'(cs_rises - b_rise), 32'd1);
        chk("t3_inactive", 32'(txr_rise_cyc - cs_rise_cyc), 32'd4);

        // DV held 5 cycles in NEXT, stray strobe in HOLD
        b_mtx = mtx_n; b_rx = rx_n; b_rise = cs_rises;
        send(3'd2, 8'h5A);
        wait_ready("t4_r2");
        tx_byte = 8'h6B;
        tx_dv = 1'b1;
        repeat (5) step();
        tx_dv = 1'b0;
        begin
            int n = 0;
            while (rx_n < b_rx + 2 && n < 100) begin step(); n = n + 1; end
        end
        chk("t4_rx_n", 32'(rx_n - b_rx), 32'd2);
        tx_byte = 8'hEE;
        tx_dv = 1'b1;
        step();
        tx_dv = 1'b0;
        wait_ready("t4_done");
        chk("t4_mtx", 32'(mtx_n - b_mtx), 32'd2);
        chk("t4_rx_b", {16'h0, rx_log_b[b_rx], rx_log_b[b_rx+1]}, 32'h5A6B);
        chk("t4_rises", 32'(cs_rises - b_rise), 32'd1);

        // Host stalls 50 cycles before byte 2
        b_mtx = mtx_n; b_rx = rx_n; b_rise = cs_rises;
        send(3'd2, 8'h77);
        wait_ready("t5_r2");
        repeat (50) step();
        chk("t5_cs_low", 32'(cs_n), 32'd0);
        chk("t5_no_dv", 32'(mtx_n - b_mtx), 32'd1);
        chk("t5_ready", 32'(tx_ready), 32'd1);
        send(3'd0, 8'h88);
        wait_ready("t5_done");
        chk("t5_last", {rx_log_b[b_rx+1], 5'h0, rx_log_c[b_rx+1]}, 16'h8802);
        chk("t5_rises", 32'(cs_rises - b_rise), 32'd1);

        // Reset during byte 2 of 3
        send(3'd3, 8'hA1);
        wait_ready("t6_r2");
        send(3'd0, 8'hB2);
        rst_n = 1'b0;
        #1;
        chk("t6_cs_n", 32'(cs_n), 32'd1);
        chk("t6_strobes", {29'h0, m_tx_dv, rx_dv, tx_ready}, 32'd0);
        chk("t6_rx_count", 32'(rx_count), 32'd0);
        step(); step();
        rst_n = 1'b1;
        wait_ready("t6_idle");
        b_rx = rx_n;
        send(3'd1, 8'h3C);
        wait_ready("t6_done");
        chk("t6_rx_n", 32'(rx_n - b_rx), 32'd1);
        chk("t6_last", {rx_log_b[b_rx], 5'h0, rx_log_c[b_rx]}, 16'h3C01);

        // Global properties across the whole run
        chk("no_b2b_mtx", 32'(mtx_b2b), 32'd0);
        chk("no_mtx_cs_hi", 32'(mtx_cs_hi), 32'd0);
        chk("ready_tracks_engine", 32'(bad_ready), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_cs_xfer_ctrl.md
Name: spi_cs_xfer_ctrl

Overview:
Multi-byte transaction controller that sits directly upstream of the team's byte-level SPI master engine. It accepts a byte count and a stream of bytes from the host logic, drives one chip-select around the whole burst, and feeds bytes one at a time to the engine's TX handshake. It collects the engine's received bytes and returns them to the host with a running index. It enforces CS setup, hold and inactive (deselect) timing in i_clk cycles.

Parameters:
MAX_BYTES, 4, maximum bytes per CS assertion (≥1); count width CW = $clog2(MAX_BYTES+1)
CS_SETUP_CLKS, 2, i_clk cycles CS_n is low before the first engine DV (≥1)
CS_HOLD_CLKS, 2, i_clk cycles CS_n stays low after the engine returns ready on the last byte (≥1)
CS_INACTIVE_CLKS, 4, i_clk cycles CS_n stays high before the next transaction may start (≥1)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_TX_Count  in  CW  bytes in this transaction; sampled only on an accepted i_TX_DV in IDLE
i_TX_Byte  in  8  host byte to send
i_TX_DV  in  1  one-cycle strobe; accepted only while o_TX_Ready=1
o_TX_Ready  out  1  controller can take the next byte
o_RX_Count  out  CW  1-based index of the byte on o_RX_Byte
o_RX_DV  out  1  one-cycle strobe; o_RX_Byte/o_RX_Count valid
o_RX_Byte  out  8  received byte
o_M_TX_Byte  out  8  byte to engine
o_M_TX_DV  out  1  one-cycle strobe to engine
i_M_TX_Ready  in  1  engine idle
i_M_RX_DV  in  1  engine byte-received strobe
i_M_RX_Byte  in  8  engine received byte
o_SPI_CS_n  out  1  active-low chip select

Behaviour:
- Reset (async, any state): state=IDLE; o_SPI_CS_n=1; o_TX_Ready=0 for the first cycle after release, then follows the rules below; o_RX_DV=0, o_M_TX_DV=0, o_RX_Byte=0, o_M_TX_Byte=0, o_RX_Count=0; all counters cleared. Reset mid-burst deasserts CS immediately.
- All outputs are registered.
- States: IDLE, SETUP, XFER, NEXT, HOLD, INACTIVE.
- IDLE: CS_n=1. o_TX_Ready=1 when i_M_TX_Ready=1.
  - i_TX_DV with i_TX_Count=0: ignored.
  - i_TX_DV with i_TX_Count>MAX_BYTES: count is clamped to MAX_BYTES.
  - Otherwise: latch the byte and the remaining count, clear o_RX_Count, drop CS_n and o_TX_Ready on the next edge, go to SETUP.
- SETUP: stays CS_SETUP_CLKS cycles. Issues o_M_TX_DV (one cycle) with the latched byte in the cycle after SETUP ends, then goes to XFER.
  - Latency: DV accepted at edge T gives CS_n=0 from T+1 and o_M_TX_DV high in cycle T+1+CS_SETUP_CLKS.
- XFER: wait for i_M_RX_DV. On it, the next cycle drives o_RX_DV=1, o_RX_Byte=i_M_RX_Byte and o_RX_Count+1, and decrements remaining.
  - remaining becomes 0: go to HOLD.
  - Otherwise: go to NEXT.
- NEXT: CS_n stays 0. o_TX_Ready=1 only while i_M_TX_Ready=1; there is no timeout.
  - Accepted i_TX_DV: latch the byte, o_TX_Ready=0, o_M_TX_DV pulses in the following cycle, go to XFER.
- HOLD: wait for i_M_TX_Ready=1, then count CS_HOLD_CLKS cycles. Then CS_n=1 and go to INACTIVE.
- INACTIVE: CS_n=1 for CS_INACTIVE_CLKS cycles, o_TX_Ready=0, then go to IDLE.
- i_TX_DV while o_TX_Ready=0: ignored, with no side effects.
- i_M_RX_DV outside XFER: ignored.
- o_M_TX_DV is never asserted in two consecutive cycles.
- o_RX_Count holds its last value until the next transaction starts.

Test Plan:
- Single byte, count=1, byte 0xA5, engine model with MISO loopback: CS_n low 2 cycles before M_TX_DV; o_RX_DV once with 0xA5 and count 1; CS_n rises 2 cycles after M_TX_Ready returns; o_TX_Ready stays low for 4 cycles after CS rises.
- Burst count=3, bytes 0x11, 0x22, 0x33: CS_n low continuously across all 3 bytes; o_RX_Count goes 1, 2, 3; o_TX_Ready pulses high between bytes only while M_TX_Ready=1; exactly 3 M_TX_DV pulses.
- Count=0 and count=7 (clamped to 4): count=0 gives no CS activity; count=7 produces exactly 4 bytes then CS deasserts.
- i_TX_DV held high for 5 cycles in NEXT, plus a strobe during HOLD: only one byte accepted; no DV is forwarded during HOLD.
- Host delays the 2nd byte by 50 cycles: CS_n stays low and M_TX_DV stays low until the byte arrives.
- i_rst_n asserted during XFER of byte 2 of 3: CS_n=1 and all strobes 0 immediately; a clean count=1 transfer completes after reset release.
